// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: round-robin set/clear arbiter driving an SR flag bank.
// Build option SR_READBACK_CHECK_EN adds q_vec readback to err.
module sr_bank_ctrl #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   op,
  input  logic [NREQ*IW-1:0] idx,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              busy,
  output logic [WIDTH-1:0]  s_vec,
  output logic [WIDTH-1:0]  r_vec,
  input  logic [WIDTH-1:0]  q_vec
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   w;
  logic [PW-1:0]   win;
  logic [PW-1:0]   w_nxt;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic            win_op;
  logic            win_rng;
  logic [WIDTH-1:0] win_oh;
  logic            crng;
  logic            err_q;

  // scan from the back so the entry closest to ptr wins
  always_comb begin
    int j;
    win_vld = 1'b0;
    win = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        win_vld = 1'b1;
        win = PW'(j);
      end
    end
  end

  assign win_idx = idx[int'(win)*IW +: IW];
  assign win_op  = op[win];
  assign win_rng = int'(win_idx) < WIDTH;
  assign win_oh  = win_rng ? (WIDTH'(1) << win_idx) : '0;
  assign w_nxt   = (int'(w) == NREQ - 1) ? '0 : w + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      w     <= '0;
      crng  <= 1'b0;
      ack   <= '0;
      err_q <= 1'b0;
      busy  <= 1'b0;
      s_vec <= '0;
      r_vec <= '0;
    end else begin
      ack   <= '0;
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            state <= DRIVE;
            busy  <= 1'b1;
            w     <= win;
            crng  <= win_rng;
            s_vec <= win_op ? win_oh : '0;
            r_vec <= win_op ? '0 : win_oh;
          end
        end
        DRIVE: begin
          state  <= DONE;
          s_vec  <= '0;
          r_vec  <= '0;
          ack[w] <= 1'b1;
          err_q  <= !crng;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ptr   <= w_nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SR_READBACK_CHECK_EN
  logic [IW-1:0] cidx;
  logic          cop;
  logic          q_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cidx <= '0;
      cop  <= 1'b0;
    end else if (state == IDLE && win_vld) begin
      cidx <= win_idx;
      cop  <= win_op;
    end
  end

  // the bank absorbed the DRIVE edge, so q_vec is current during DONE
  assign q_bit = |(q_vec & (WIDTH'(1) << cidx));
  assign err = err_q | (state == DONE && crng && q_bit != cop);
`else
  logic unused_q;
  assign unused_q = ^q_vec;
  assign err = err_q;
`endif

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: vector table, corner sequences and randomized
// traffic against a cycle-schedule model for sr_bank_ctrl.
module tb_sr_bank_ctrl;
  localparam int NREQ = 4;
  localparam int WIDTH = 6;
  localparam int IW = 3;
  localparam int NR = 600;

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] req, op, ack;
  logic [NREQ*IW-1:0] idx;
  logic err, busy;
  logic [WIDTH-1:0] s_vec, r_vec, q_vec;
  logic [WIDTH-1:0] bank = '0;
  logic [WIDTH-1:0] qmask = '1;

  int total = 0;
  int bad = 0;

  sr_bank_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
    .ack(ack), .err(err), .busy(busy),
    .s_vec(s_vec), .r_vec(r_vec), .q_vec(q_vec)
  );

  always #5 clk = ~clk;

  // behavioural SR bank
  always @(posedge clk)
    bank <= (bank | (s_vec & ~r_vec)) & ~(r_vec & ~s_vec);

  assign q_vec = bank & qmask;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(int i, bit o, int x);
    req[i] = 1'b1;
    op[i] = o;
    idx[i*IW +: IW] = IW'(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    op = '0;
    idx = '0;
    repeat (2) @(negedge clk);
    chk("rst ack", ack, 0);
    chk("rst err", err, 0);
    chk("rst busy", busy, 0);
    chk("rst s", s_vec, 0);
    chk("rst r", r_vec, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(output int who, output int t);
    who = -1;
    t = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("s_and_r", s_vec & r_vec, 0);
      if (ack != 0) begin
        t = n;
        for (int i = 0; i < NREQ; i++) if (ack[i]) who = i;
        chk("ack onehot", $countones(ack), 1);
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL ack timeout: got none want ack within 12 cycles");
  endtask

  typedef struct {
    int r;
    bit o;
    int x;
    logic [WIDTH-1:0] es;
    logic [WIDTH-1:0] er;
    logic [NREQ-1:0] ea;
    bit ee;
  } vec_t;

  function automatic vec_t mk(int r, bit o, int x, logic [WIDTH-1:0] es,
                              logic [WIDTH-1:0] er, logic [NREQ-1:0] ea, bit ee);
    vec_t v;
    v.r = r; v.o = o; v.x = x; v.es = es; v.er = er; v.ea = ea; v.ee = ee;
    return v;
  endfunction

  vec_t tbl [7];

  logic [WIDTH-1:0] es_a [NR+8];
  logic [WIDTH-1:0] er_a [NR+8];
  logic [NREQ-1:0]  ea_a [NR+8];
  bit               ee_a [NR+8];
  bit               eb_a [NR+8];

  initial begin
    int who, t;
    bit exp_rb;
    int ptr_m, free_at;
    bit [NREQ-1:0] gr_m;

    tbl[0] = mk(1, 1'b1, 3, 6'h08, 6'h00, 4'b0010, 1'b0);
    tbl[1] = mk(0, 1'b0, 7, 6'h00, 6'h00, 4'b0001, 1'b1);
    tbl[2] = mk(2, 1'b1, 5, 6'h20, 6'h00, 4'b0100, 1'b0);
    tbl[3] = mk(3, 1'b0, 3, 6'h00, 6'h08, 4'b1000, 1'b0);
    tbl[4] = mk(0, 1'b0, 0, 6'h00, 6'h01, 4'b0001, 1'b0);
    tbl[5] = mk(1, 1'b1, 6, 6'h00, 6'h00, 4'b0010, 1'b1);
    tbl[6] = mk(2, 1'b1, 5, 6'h20, 6'h00, 4'b0100, 1'b0);

    do_reset();

    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].o, tbl[n].x);
      @(negedge clk);
      chk("tbl s", s_vec, tbl[n].es);
      chk("tbl r", r_vec, tbl[n].er);
      chk("tbl busy1", busy, 1);
      chk("tbl ack0", ack, 0);
      @(negedge clk);
      chk("tbl ack", ack, tbl[n].ea);
      chk("tbl err", err, tbl[n].ee);
      chk("tbl s off", s_vec | r_vec, 0);
      if (tbl[n].x < WIDTH) chk("tbl q", q_vec[tbl[n].x], tbl[n].o);
      req[tbl[n].r] = 1'b0;
      @(negedge clk);
      chk("tbl idle", {busy, ack}, 0);
    end

    // all four at once, from ptr 0
    do_reset();
    drive(0, 1'b1, 0);
    drive(1, 1'b0, 1);
    drive(2, 1'b1, 2);
    drive(3, 1'b1, 4);
    for (int i = 0; i < NREQ; i++) begin
      wait_ack(who, t);
      chk("rr4 who", who, i);
      chk("rr4 gap", t, (i == 0) ? 2 : 3);
      if (who >= 0) req[who] = 1'b0;
    end

    // serve 2, then 2 and 0 together: ptr=3 wraps to 0 first
    @(negedge clk);
    drive(2, 1'b1, 1);
    wait_ack(who, t);
    chk("wrap first", who, 2);
    req[2] = 1'b0;
    @(negedge clk);
    drive(2, 1'b0, 1);
    drive(0, 1'b1, 3);
    wait_ack(who, t);
    chk("wrap a", who, 0);
    req[0] = 1'b0;
    wait_ack(who, t);
    chk("wrap b", who, 2);
    chk("wrap b gap", t, 3);
    req[2] = 1'b0;

    // reset landing in DRIVE
    @(negedge clk);
    drive(3, 1'b1, 2);
    @(negedge clk);
    chk("mid s", s_vec, 6'h04);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid sr off", s_vec | r_vec, 0);
    chk("mid no ack", ack, 0);
    chk("mid busy", busy, 0);
    rst_n = 1'b1;
    wait_ack(who, t);
    chk("mid regrant", who, 3);
    chk("mid lat", t, 2);
    req[3] = 1'b0;

    // readback disagreement on bit 5
`ifdef SR_READBACK_CHECK_EN
    exp_rb = 1'b1;
`else
    exp_rb = 1'b0;
`endif
    @(negedge clk);
    qmask = ~6'h20;
    drive(1, 1'b1, 5);
    wait_ack(who, t);
    chk("rb who", who, 1);
    chk("rb err", err, exp_rb);
    req[1] = 1'b0;
    @(negedge clk);
    qmask = '1;

    // randomized traffic against a cycle schedule
    do_reset();
    for (int c = 0; c < NR + 8; c++) begin
      es_a[c] = '0; er_a[c] = '0; ea_a[c] = '0; ee_a[c] = 0; eb_a[c] = 0;
    end
    ptr_m = 0;
    free_at = 0;
    gr_m = '0;
    for (int c = 0; c < NR; c++) begin
      chk("rnd s", s_vec, es_a[c]);
      chk("rnd r", r_vec, er_a[c]);
      chk("rnd ack", ack, ea_a[c]);
      chk("rnd err", err, ee_a[c]);
      chk("rnd busy", busy, eb_a[c]);
      for (int i = 0; i < NREQ; i++) begin
        if (ea_a[c][i]) begin
          req[i] = 1'b0;
          gr_m[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0)
            drive(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end else if (gr_m[i]) begin
          op[i] = 1'($urandom_range(0, 1));
          idx[i*IW +: IW] = IW'($urandom_range(0, 7));
        end
      end
      if (c + 1 >= free_at && req != 0) begin
        int w, x;
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
        x = int'(idx[w*IW +: IW]);
        if (x < WIDTH) begin
          if (op[w]) es_a[c+1] = WIDTH'(1) << x;
          else er_a[c+1] = WIDTH'(1) << x;
        end
        eb_a[c+1] = 1;
        eb_a[c+2] = 1;
        ea_a[c+2][w] = 1'b1;
        ee_a[c+2] = (x >= WIDTH);
        ptr_m = (w + 1) % NREQ;
        free_at = c + 4;
        gr_m[w] = 1'b1;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
